// File: rtl/x_mod_seq_reducer.sv
// x_mod_seq_reducer: sequential X mod MOD reducer, CHUNK bits per clock, MSB-first.
// Ports: clk, rst (async, active-high), in_valid/in_ready/X operand side,
//        out_valid/out_ready/R result side, busy (high while folding).
module x_mod_seq_reducer #(
    parameter int W_IN  = 100,
    parameter int MOD   = 997,
    parameter int W_R   = 10,
    parameter int CHUNK = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [W_IN-1:0] X,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [W_R-1:0]  R,
    output logic            busy
);

    localparam int NCH = (W_IN + CHUNK - 1) / CHUNK;
    localparam int PW  = NCH * CHUNK;
    localparam int CW  = $clog2(NCH + 1);

    localparam logic [W_R:0]  MODV = (W_R + 1)'(MOD);
    localparam logic [CW-1:0] LAST = CW'(NCH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t          state;
    logic [PW-1:0]   sr;
    logic [W_R-1:0]  acc;
    logic [W_R-1:0]  acc_nxt;
    logic [CW-1:0]   cnt;
    logic [CHUNK-1:0] chunk;
    logic [W_R:0]    t;
    logic            take;

    assign chunk    = sr[PW-1 -: CHUNK];
    assign in_ready = (state == IDLE) ||
                      ((state == DONE) && out_ready);
    assign take     = in_valid && in_ready;

    // Horner fold: each step doubles acc, adds the next bit and
    // subtracts MOD once; t < 2*MOD keeps acc < MOD after every step.
    always_comb begin
        t       = '0;
        acc_nxt = acc;
        for (int i = CHUNK - 1; i >= 0; i--) begin
            t = {acc_nxt, chunk[i]};
            if (t >= MODV)
                t = t - MODV;
            acc_nxt = t[W_R-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            sr        <= '0;
            acc       <= '0;
            cnt       <= '0;
            R         <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (take) begin
                        sr    <= PW'(X);
                        acc   <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    acc <= acc_nxt;
                    sr  <= sr << CHUNK;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        R         <= acc_nxt;
                        out_valid <= 1'b1;
                        busy      <= 1'b0;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        // Accept the next operand on the same edge
                        // the result is consumed.
                        if (in_valid) begin
                            sr    <= PW'(X);
                            acc   <= '0;
                            cnt   <= '0;
                            busy  <= 1'b1;
                            state <= RUN;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_x_mod_seq_reducer.sv
// tb_x_mod_seq_reducer: randomized bench for x_mod_seq_reducer against
// a wide-arithmetic modulo reference, plus parameter-sweep instances.
module tb_x_mod_seq_reducer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [99:0] x = '0;
    logic        in_ready;
    logic        out_valid;
    logic        busy;
    logic [9:0]  r;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    x_mod_seq_reducer dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .X(x), .out_valid(out_valid), .out_ready(out_ready),
        .R(r), .busy(busy)
    );

    logic        sw_valid = 1'b0;
    logic [99:0] sw_x = '0;
    logic [6:0]  s_ir, s_ov, s_bz;
    logic [9:0]  r0, r1, r2, r4, r5;
    logic [1:0]  r3, r6;

    x_mod_seq_reducer #(.W_IN(100), .MOD(997), .W_R(10), .CHUNK(1)) s0 (
        .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(s_ir[0]),
        .X(sw_x), .out_valid(s_ov[0]), .out_ready(1'b1),
        .R(r0), .busy(s_bz[0]));
    x_mod_seq_reducer #(.W_IN(100), .MOD(997), .W_R(10), .CHUNK(7)) s1 (
        .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(s_ir[1]),
        .X(sw_x), .out_valid(s_ov[1]), .out_ready(1'b1),
        .R(r1), .busy(s_bz[1]));
    x_mod_seq_reducer #(.W_IN(100), .MOD(997), .W_R(10), .CHUNK(100)) s2 (
        .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(s_ir[2]),
        .X(sw_x), .out_valid(s_ov[2]), .out_ready(1'b1),
        .R(r2), .busy(s_bz[2]));
    x_mod_seq_reducer #(.W_IN(100), .MOD(3), .W_R(2), .CHUNK(6)) s3 (
        .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(s_ir[3]),
        .X(sw_x), .out_valid(s_ov[3]), .out_ready(1'b1),
        .R(r3), .busy(s_bz[3]));
    x_mod_seq_reducer #(.W_IN(100), .MOD(1021), .W_R(10), .CHUNK(6)) s4 (
        .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(s_ir[4]),
        .X(sw_x), .out_valid(s_ov[4]), .out_ready(1'b1),
        .R(r4), .busy(s_bz[4]));
    x_mod_seq_reducer #(.W_IN(16), .MOD(1021), .W_R(10), .CHUNK(5)) s5 (
        .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(s_ir[5]),
        .X(sw_x[15:0]), .out_valid(s_ov[5]), .out_ready(1'b1),
        .R(r5), .busy(s_bz[5]));
    x_mod_seq_reducer #(.W_IN(16), .MOD(3), .W_R(2), .CHUNK(16)) s6 (
        .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(s_ir[6]),
        .X(sw_x[15:0]), .out_valid(s_ov[6]), .out_ready(1'b1),
        .R(r6), .busy(s_bz[6]));

    localparam int SW_NCH [7] = '{100, 15, 1, 17, 17, 4, 1};
    localparam int SW_MOD [7] = '{997, 997, 997, 3, 1021, 1021, 3};
    localparam int SW_W   [7] = '{100, 100, 100, 100, 100, 16, 16};

    function automatic logic [9:0] ref_mod(input logic [99:0] v, input int m);
        logic [127:0] ve;
        logic [127:0] q;
        ve = {28'b0, v};
        q  = ve % 128'(m);
        return q[9:0];
    endfunction

    function automatic logic [99:0] rnd100();
        logic [127:0] t;
        t = {$urandom, $urandom, $urandom, $urandom};
        return t[99:0];
    endfunction

    task automatic run_one(input logic [99:0] xv, output int lat,
                           output logic [9:0] rv);
        int n;
        @(negedge clk);
        x = xv;
        in_valid = 1'b1;
        out_ready = 1'b1;
        n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!out_valid && lat < 300);
        rv = r;
    endtask

    task automatic test_reset();
        int lat;
        logic [9:0] rv;
        int seen;
        rst = 1'b1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if (out_valid !== 1'b0 || r !== 10'd0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state: ov=%b R=%0d busy=%b want 0 0 0",
                     out_valid, r, busy);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_vec++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
        run_one(100'd998, lat, rv);
        n_vec++;
        if (rv !== 10'd1) begin
            n_err++;
            $display("FAIL pre_reset_op: R=%0d want 1", rv);
        end
        @(negedge clk);
        x = rnd100();
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        n_vec++;
        if (busy !== 1'b1 || in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL mid_run: busy=%b in_ready=%b want 1 0",
                     busy, in_ready);
        end
        rst = 1'b1;
        #1;
        n_vec++;
        if (out_valid !== 1'b0 || r !== 10'd0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL mid_run_reset: ov=%b R=%0d busy=%b want 0 0 0",
                     out_valid, r, busy);
        end
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (25) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        n_vec++;
        if (seen != 0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_discard: ov_cycles=%0d in_ready=%b want 0 1",
                     seen, in_ready);
        end
        run_one(100'd5, lat, rv);
        n_vec++;
        if (rv !== 10'd5 || lat != 17) begin
            n_err++;
            $display("FAIL post_reset_x5: R=%0d lat=%0d want 5 17", rv, lat);
        end
    endtask

    task automatic test_basic();
        logic [99:0] xs [5] = '{100'd0, 100'd996, 100'd997, 100'd998,
                                100'd1234567};
        logic [9:0]  es [5] = '{10'd0, 10'd996, 10'd0, 10'd1, 10'd281};
        int lat;
        logic [9:0] rv;
        logic [99:0] xr;
        for (int i = 0; i < 5; i++) begin
            run_one(xs[i], lat, rv);
            n_vec++;
            if (rv !== es[i] || lat != 17) begin
                n_err++;
                $display("FAIL basic[%0d]: X=%0d R=%0d lat=%0d want %0d 17",
                         i, xs[i], rv, lat, es[i]);
            end
        end
        for (int i = 0; i < 8; i++) begin
            xr = rnd100();
            if (i < 4) xr = xr >> (25 * i);
            run_one(xr, lat, rv);
            n_vec++;
            if (rv !== ref_mod(xr, 997) || lat != 17) begin
                n_err++;
                $display("FAIL rand[%0d]: X=%h R=%0d lat=%0d want %0d 17",
                         i, xr, rv, lat, ref_mod(xr, 997));
            end
        end
    endtask

    task automatic test_full_range();
        logic [99:0] a;
        logic [99:0] b;
        int lat;
        logic [9:0] rv;
        a = '1;
        b = a - 100'd996;
        run_one(a, lat, rv);
        n_vec++;
        if (rv !== 10'd906 || lat != 17) begin
            n_err++;
            $display("FAIL full_max: R=%0d lat=%0d want 906 17", rv, lat);
        end
        run_one(b, lat, rv);
        n_vec++;
        if (rv !== 10'd907 || lat != 17) begin
            n_err++;
            $display("FAIL full_max_m997: R=%0d lat=%0d want 907 17", rv, lat);
        end
    endtask

    task automatic test_back_to_back();
        logic [99:0] xs [3] = '{100'd997, 100'd998, 100'd999};
        int acc_e [$];
        int pv_e [$];
        logic [9:0] pv_r [$];
        int k;
        int idle;
        logic acc;
        k = 0;
        idle = 0;
        @(negedge clk);
        out_ready = 1'b1;
        x = xs[0];
        in_valid = 1'b1;
        acc = in_valid && in_ready;
        for (int e = 1; e <= 80; e++) begin
            @(posedge clk);
            #1;
            if (acc) begin
                acc_e.push_back(e);
                k++;
                if (k < 3) x = xs[k];
                else in_valid = 1'b0;
            end
            if (out_valid) begin
                pv_e.push_back(e);
                pv_r.push_back(r);
            end
            if (acc_e.size() > 0 && pv_e.size() < 3 && !busy && !out_valid)
                idle++;
            acc = in_valid && in_ready;
        end
        n_vec++;
        if (pv_e.size() != 3 || acc_e.size() != 3 || idle != 0) begin
            n_err++;
            $display("FAIL b2b_count: pulses=%0d accepts=%0d idle=%0d want 3 3 0",
                     pv_e.size(), acc_e.size(), idle);
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_vec++;
                if (pv_r[i] !== 10'(i) || pv_e[i] - acc_e[i] != 17) begin
                    n_err++;
                    $display("FAIL b2b[%0d]: R=%0d lat=%0d want %0d 17",
                             i, pv_r[i], pv_e[i] - acc_e[i], i);
                end
                if (i > 0) begin
                    n_vec++;
                    if (acc_e[i] != pv_e[i-1] + 1) begin
                        n_err++;
                        $display("FAIL b2b_gap[%0d]: accept_edge=%0d want %0d",
                                 i, acc_e[i], pv_e[i-1] + 1);
                    end
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [99:0] xa;
        logic [99:0] xb;
        logic [9:0] held;
        int lat;
        int bad;
        xa = rnd100();
        xb = rnd100();
        @(negedge clk);
        out_ready = 1'b0;
        x = xa;
        in_valid = 1'b1;
        lat = 0;
        while (!in_ready && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        @(posedge clk);
        #1;
        x = xb;
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!out_valid && lat < 300);
        n_vec++;
        if (r !== ref_mod(xa, 997) || lat != 17) begin
            n_err++;
            $display("FAIL bp_first: R=%0d lat=%0d want %0d 17",
                     r, lat, ref_mod(xa, 997));
        end
        held = r;
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            n_vec++;
            if (r !== held || out_valid !== 1'b1 || in_ready !== 1'b0 ||
                busy !== 1'b0) begin
                n_err++;
                $display("FAIL bp_hold[%0d]: R=%0d ov=%b ir=%b busy=%b want %0d 1 0 0",
                         i, r, out_valid, in_ready, busy, held);
            end
        end
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        n_vec++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL bp_release_ready: got %b want 1", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        n_vec++;
        if (out_valid !== 1'b0 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL bp_accept: ov=%b busy=%b want 0 1", out_valid, busy);
        end
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!out_valid && lat < 300);
        n_vec++;
        if (r !== ref_mod(xb, 997) || lat != 17) begin
            n_err++;
            $display("FAIL bp_second: R=%0d lat=%0d want %0d 17",
                     r, lat, ref_mod(xb, 997));
        end
    endtask

    task automatic test_param_sweep();
        int lat [7];
        logic [9:0] res [7];
        logic [9:0] rs [7];
        logic [99:0] xm;
        int n;
        for (int v = 0; v < 6; v++) begin
            n = 0;
            while (s_ir != 7'h7f && n < 300) begin
                @(negedge clk);
                n++;
            end
            @(negedge clk);
            sw_x = rnd100();
            if (v == 0) sw_x = '1;
            sw_valid = 1'b1;
            @(posedge clk);
            #1;
            sw_valid = 1'b0;
            for (int i = 0; i < 7; i++) begin
                lat[i] = 0;
                res[i] = '0;
            end
            for (int c = 1; c <= 110; c++) begin
                @(posedge clk);
                #1;
                rs = '{r0, r1, r2, {8'b0, r3}, r4, r5, {8'b0, r6}};
                for (int i = 0; i < 7; i++)
                    if (s_ov[i] && lat[i] == 0) begin
                        lat[i] = c;
                        res[i] = rs[i];
                    end
            end
            for (int i = 0; i < 7; i++) begin
                xm = (SW_W[i] == 16) ? {84'b0, sw_x[15:0]} : sw_x;
                n_vec++;
                if (lat[i] != SW_NCH[i] || res[i] !== ref_mod(xm, SW_MOD[i])) begin
                    n_err++;
                    $display("FAIL sweep[%0d] v%0d: R=%0d lat=%0d want %0d %0d",
                             i, v, res[i], lat[i], ref_mod(xm, SW_MOD[i]),
                             SW_NCH[i]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full_range();
        test_back_to_back();
        test_backpressure();
        test_param_sweep();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
